// File: rtl/mdu_hilo.sv
// ============================================================================
// Module   : mdu_hilo
// Summary  : Multi-cycle multiply/divide unit owning the MIPS HI/LO registers.
//            The multiply-accumulate ops (MADD/MADDU) are built in only when
//            the MDU_MADD_EN macro is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_hilo #(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        Start,
    input  logic [2:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] Hi,
    output logic [31:0] Lo
);

    localparam logic [2:0] c_OP_MULT  = 3'd0;
    localparam logic [2:0] c_OP_MULTU = 3'd1;
    localparam logic [2:0] c_OP_DIV   = 3'd2;
    localparam logic [2:0] c_OP_DIVU  = 3'd3;
    localparam logic [2:0] c_OP_MTHI  = 3'd4;
    localparam logic [2:0] c_OP_MTLO  = 3'd5;
`ifdef MDU_MADD_EN
    localparam logic [2:0] c_OP_MADD  = 3'd6;
    localparam logic [2:0] c_OP_MADDU = 3'd7;
`endif

    localparam logic [3:0] c_MUL_CNT = 4'(MUL_LAT);
    localparam logic [3:0] c_DIV_CNT = 4'(DIV_LAT);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic        w_launch;
    logic        w_done;
    logic        w_is_mul;
    logic        w_is_div;
    logic        w_mt_hi;
    logic        w_mt_lo;

    logic [2:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
`ifdef MDU_MADD_EN
    logic [63:0] r_acc;
`endif

    // ------------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_is_mul = (Op == c_OP_MULT) || (Op == c_OP_MULTU);
`ifdef MDU_MADD_EN
        w_is_mul = w_is_mul || (Op == c_OP_MADD) || (Op == c_OP_MADDU);
`endif
        w_is_div = (Op == c_OP_DIV) || (Op == c_OP_DIVU);
        w_mt_hi  = Start && (r_state == ST_IDLE) && (Op == c_OP_MTHI);
        w_mt_lo  = Start && (r_state == ST_IDLE) && (Op == c_OP_MTLO);
    end

    // ------------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_launch    = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (Start && (w_is_mul || w_is_div)) begin
                    w_launch    = 1'b1;
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = w_is_mul ? c_MUL_CNT : c_DIV_CNT;
                end
            end
            ST_RUN: begin
                // Result lands on the same edge the counter reaches zero.
                if (r_cnt == 4'd1) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_cnt_nxt   = r_cnt - 4'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    assign Busy = (r_state == ST_RUN);

    // ------------------------------------------------------------------------
    // Result datapath on the latched operands
    // ------------------------------------------------------------------------
    logic        w_signed;
    logic        w_op_div;
    logic [63:0] w_mul_a;
    logic [63:0] w_mul_b;
    logic [63:0] w_prod;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_divisor;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    logic [63:0] w_mul_res;
    logic [63:0] w_result;

    always_comb begin
        w_signed = (r_op == c_OP_MULT) || (r_op == c_OP_DIV);
`ifdef MDU_MADD_EN
        w_signed = w_signed || (r_op == c_OP_MADD);
`endif
        w_op_div = (r_op == c_OP_DIV) || (r_op == c_OP_DIVU);
    end

    // Low 64 bits of a 64x64 product are correct for both signednesses
    // once the operands are extended the right way.
    assign w_mul_a = {{32{w_signed & r_a[31]}}, r_a};
    assign w_mul_b = {{32{w_signed & r_b[31]}}, r_b};
    assign w_prod  = w_mul_a * w_mul_b;

`ifdef MDU_MADD_EN
    assign w_mul_res = ((r_op == c_OP_MADD) || (r_op == c_OP_MADDU)) ?
                       (r_acc + w_prod) : w_prod;
`else
    assign w_mul_res = w_prod;
`endif

    // Sign-magnitude division: truncation toward zero, remainder follows the
    // dividend. 0x80000000 / -1 wraps back to 0x80000000 naturally.
    assign w_a_neg   = w_signed & r_a[31];
    assign w_b_neg   = w_signed & r_b[31];
    assign w_a_mag   = w_a_neg ? (~r_a + 32'd1) : r_a;
    assign w_b_mag   = w_b_neg ? (~r_b + 32'd1) : r_b;
    assign w_divisor = (w_b_mag == 32'd0) ? 32'd1 : w_b_mag;
    assign w_q_mag   = w_a_mag / w_divisor;
    assign w_r_mag   = w_a_mag % w_divisor;
    assign w_quo     = (w_a_neg ^ w_b_neg) ? (~w_q_mag + 32'd1) : w_q_mag;
    assign w_rem     = w_a_neg ? (~w_r_mag + 32'd1) : w_r_mag;

    always_comb begin
        w_result = w_mul_res;
        if (w_op_div) begin
            if (r_b == 32'd0) begin
                w_result = {r_a, 32'hFFFF_FFFF};
            end else begin
                w_result = {w_rem, w_quo};
            end
        end
    end

    // ------------------------------------------------------------------------
    // Operand latch and HI/LO registers
    // ------------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_op  <= 3'd0;
            r_a   <= 32'd0;
            r_b   <= 32'd0;
            r_hi  <= 32'd0;
            r_lo  <= 32'd0;
`ifdef MDU_MADD_EN
            r_acc <= 64'd0;
`endif
        end else begin
            if (w_launch) begin
                r_op  <= Op;
                r_a   <= A;
                r_b   <= B;
`ifdef MDU_MADD_EN
                r_acc <= {r_hi, r_lo};
`endif
            end
            if (w_mt_hi) begin
                r_hi <= A;
            end
            if (w_mt_lo) begin
                r_lo <= A;
            end
            if (w_done) begin
                r_hi <= w_result[63:32];
                r_lo <= w_result[31:0];
            end
        end
    end

    assign Hi = r_hi;
    assign Lo = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_mdu_hilo.sv
// ============================================================================
// Module   : tb_mdu_hilo
// Summary  : Self-checking bench for mdu_hilo: per-cycle model comparison plus
//            directed vectors with hand-computed results.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mdu_hilo;

    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 10;

    logic        Clk;
    logic        Rst_n;
    logic        Start;
    logic [2:0]  Op;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic [31:0] Hi;
    logic [31:0] Lo;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    mdu_hilo #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) u_dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .Start (Start),
        .Op    (Op),
        .A     (A),
        .B     (B),
        .Busy  (Busy),
        .Hi    (Hi),
        .Lo    (Lo)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: arithmetic straight from the instruction definitions
    // ------------------------------------------------------------------------
    function automatic logic [63:0] exp_mul(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'h0, a});
            sb = longint'({32'h0, b});
        end
        return 64'(sa * sb);
    endfunction

    function automatic logic [63:0] exp_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        int ia;
        int ib;
        int q;
        int r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (sgn) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
            ia = a;
            ib = b;
            q  = ia / ib;
            r  = ia % ib;
            return {32'(r), 32'(q)};
        end
        return {a % b, a / b};
    endfunction

    logic [31:0] m_hi   = '0;
    logic [31:0] m_lo   = '0;
    logic [63:0] m_pend = '0;
    int          m_rem  = 0;

    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            m_hi   <= '0;
            m_lo   <= '0;
            m_pend <= '0;
            m_rem  <= 0;
        end else if (m_rem != 0) begin
            m_rem <= m_rem - 1;
            if (m_rem == 1) begin
                m_hi <= m_pend[63:32];
                m_lo <= m_pend[31:0];
            end
        end else if (Start) begin
            case (Op)
                3'd0: begin m_pend <= exp_mul(1'b1, A, B); m_rem <= MUL_LAT; end
                3'd1: begin m_pend <= exp_mul(1'b0, A, B); m_rem <= MUL_LAT; end
                3'd2: begin m_pend <= exp_div(1'b1, A, B); m_rem <= DIV_LAT; end
                3'd3: begin m_pend <= exp_div(1'b0, A, B); m_rem <= DIV_LAT; end
                3'd4: m_hi <= A;
                3'd5: m_lo <= A;
`ifdef MDU_MADD_EN
                3'd6: begin m_pend <= {m_hi, m_lo} + exp_mul(1'b1, A, B); m_rem <= MUL_LAT; end
                3'd7: begin m_pend <= {m_hi, m_lo} + exp_mul(1'b0, A, B); m_rem <= MUL_LAT; end
`endif
                default: ;
            endcase
        end
    end

    always @(negedge Clk) begin
        if (chk_en) begin
            check("model_busy", {31'd0, Busy}, {31'd0, (m_rem != 0)});
            check("model_hi", Hi, m_hi);
            check("model_lo", Lo, m_lo);
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers (callers sit on a falling edge)
    // ------------------------------------------------------------------------
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        Start = 1'b1;
        Op    = op;
        A     = a;
        B     = b;
        @(negedge Clk);
        Start = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (Busy && n < 40) begin
            n++;
            @(negedge Clk);
        end
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int lat);
        int n;
        issue(op, a, b);
        wait_idle(n);
        check(name, 32'(n), 32'(lat));
    endtask

    int n;

    initial begin
        Rst_n = 1'b0;
        Start = 1'b0;
        Op    = 3'd0;
        A     = '0;
        B     = '0;
        repeat (3) @(negedge Clk);
        Rst_n  = 1'b1;
        chk_en = 1'b1;
        check("reset_hi", Hi, 32'h0);
        check("reset_lo", Lo, 32'h0);
        check("reset_busy", {31'd0, Busy}, 32'd0);

        // Asynchronous reset between edges clears state immediately
        issue(3'd4, 32'hDEAD_0001, 32'h0);
        issue(3'd5, 32'hBEEF_0002, 32'h0);
        check("mthi_value", Hi, 32'hDEAD_0001);
        check("mtlo_value", Lo, 32'hBEEF_0002);
        @(posedge Clk);
        #3 Rst_n = 1'b0;
        #1;
        check("async_rst_hi", Hi, 32'h0);
        check("async_rst_lo", Lo, 32'h0);
        @(negedge Clk);
        Rst_n = 1'b1;

        run_op("mult_busy_cycles", 3'd0, 32'hFFFF_FFFE, 32'd3, MUL_LAT);
        check("mult_hi", Hi, 32'hFFFF_FFFF);
        check("mult_lo", Lo, 32'hFFFF_FFFA);

        run_op("multu_busy_cycles", 3'd1, 32'hFFFF_FFFE, 32'd3, MUL_LAT);
        check("multu_hi", Hi, 32'h0000_0002);
        check("multu_lo", Lo, 32'hFFFF_FFFA);

        run_op("div_busy_cycles", 3'd2, 32'hFFFF_FFF9, 32'd2, DIV_LAT);
        check("div_lo", Lo, 32'hFFFF_FFFD);
        check("div_hi", Hi, 32'hFFFF_FFFF);

        run_op("divu_zero_busy", 3'd3, 32'd7, 32'd0, DIV_LAT);
        check("divu_zero_lo", Lo, 32'hFFFF_FFFF);
        check("divu_zero_hi", Hi, 32'd7);

        run_op("div_ovf_busy", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, DIV_LAT);
        check("div_ovf_lo", Lo, 32'h8000_0000);
        check("div_ovf_hi", Hi, 32'h0);

        run_op("div_neg_divisor_busy", 3'd2, 32'd7, 32'hFFFF_FFFE, DIV_LAT);
        check("div_negb_lo", Lo, 32'hFFFF_FFFD);
        check("div_negb_hi", Hi, 32'd1);

        // MTLO while busy is dropped; MTLO and MULT right after completion land
        issue(3'd0, 32'd3, 32'd4);
        issue(3'd5, 32'h0000_1234, 32'h0);
        wait_idle(n);
        check("busy_mtlo_ignored_lo", Lo, 32'd12);
        check("busy_mtlo_ignored_hi", Hi, 32'd0);
        issue(3'd5, 32'h0000_1234, 32'h0);
        check("mtlo_after_done_lo", Lo, 32'h0000_1234);
        check("mtlo_no_busy", {31'd0, Busy}, 32'd0);
        issue(3'd0, 32'h0001_0000, 32'h0001_0000);
        check("b2b_mult_accepted", {31'd0, Busy}, 32'd1);
        wait_idle(n);
        check("b2b_mult_hi", Hi, 32'd1);
        check("b2b_mult_lo", Lo, 32'd0);

        // Operand changes after acceptance have no effect
        issue(3'd3, 32'd100, 32'd7);
        A = 32'hFFFF_0000;
        B = 32'd3;
        wait_idle(n);
        check("hold_lo", Lo, 32'd14);
        check("hold_hi", Hi, 32'd2);

        // Reset in busy cycle 3 aborts the divide for good
        issue(3'd2, 32'd100, 32'd3);
        repeat (2) @(negedge Clk);
        @(posedge Clk);
        #2 Rst_n = 1'b0;
        #1;
        check("abort_hi", Hi, 32'h0);
        check("abort_lo", Lo, 32'h0);
        check("abort_busy", {31'd0, Busy}, 32'd0);
        @(negedge Clk);
        Rst_n = 1'b1;
        repeat (15) @(negedge Clk);
        check("abort_hold_hi", Hi, 32'h0);
        check("abort_hold_lo", Lo, 32'h0);

        // Multiply-accumulate (or its absence)
        issue(3'd4, 32'h0, 32'h0);
        issue(3'd5, 32'hFFFF_FFFF, 32'h0);
        issue(3'd6, 32'd1, 32'd1);
`ifdef MDU_MADD_EN
        check("madd_busy", {31'd0, Busy}, 32'd1);
        wait_idle(n);
        check("madd_hi", Hi, 32'd1);
        check("madd_lo", Lo, 32'd0);
`else
        check("madd_off_busy", {31'd0, Busy}, 32'd0);
        wait_idle(n);
        check("madd_off_hi", Hi, 32'd0);
        check("madd_off_lo", Lo, 32'hFFFF_FFFF);
`endif

        repeat (2) @(negedge Clk);
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
